// File: rtl/simon_round_ctrl.sv
// simon_round_ctrl
// Round sequencer for a multi-level Simon game. It captures a MAX_LEN-colour
// pattern on start and then runs one round per level. Each round plays
// colours 0..level-1 on the one-hot LEDs with timed on/off gaps. It then
// checks the player's presses in order, with an inactivity timeout. At the
// end of a round it advances the level or finishes the game in WIN or LOSE.
//
// Ports
//   clk         in   rising-edge system clock
//   reset       in   asynchronous active-high reset, forces IDLE
//   start       in   1-cycle pulse, begins a new game (ignored while busy)
//   pattern_in  in   colour i at bits [2i+1:2i], 0=B 1=G 2=R 3=Y
//   btn_valid   in   1-cycle pulse, player pressed btn_color
//   btn_color   in   colour pressed, qualified by btn_valid
//   led         out  one-hot colour display, bit n = colour n
//   level       out  current level 1..MAX_LEN, 0 after reset
//   busy        out  high in every state except IDLE/WIN/LOSE
//   round_ok    out  1-cycle pulse in LEVEL_UP
//   win         out  high while in WIN
//   lose        out  high while in LOSE
//   state_dbg   out  state encoding for the HEX display
module simon_round_ctrl #(
  parameter int MAX_LEN   = 8,
  parameter int ON_TICKS  = 4,
  parameter int OFF_TICKS = 2,
  parameter int TIMEOUT   = 64
) (
  input  logic                   clk,
  input  logic                   reset,
  input  logic                   start,
  input  logic [2*MAX_LEN-1:0]   pattern_in,
  input  logic                   btn_valid,
  input  logic [1:0]             btn_color,
  output logic [3:0]             led,
  output logic [3:0]             level,
  output logic                   busy,
  output logic                   round_ok,
  output logic                   win,
  output logic                   lose,
  output logic [3:0]             state_dbg
);

  // One timer serves playback on/off phases and the input timeout, so it is
  // sized for the longest of the three intervals.
  localparam int MAXT_A = (ON_TICKS > OFF_TICKS) ? ON_TICKS : OFF_TICKS;
  localparam int MAXT   = (MAXT_A > TIMEOUT) ? MAXT_A : TIMEOUT;
  localparam int TW     = (MAXT > 1) ? $clog2(MAXT) : 1;

  localparam logic [TW-1:0] ON_LAST    = TW'(ON_TICKS - 1);
  localparam logic [TW-1:0] OFF_LAST   = TW'(OFF_TICKS - 1);
  localparam logic [TW-1:0] TO_LAST    = TW'(TIMEOUT - 1);
  localparam logic [3:0]    LAST_LEVEL = 4'(MAX_LEN);

  // idx and level are 4 bits wide, so longer games cannot be represented.
  generate
    if (MAX_LEN < 1 || MAX_LEN > 15) begin : g_bad_max_len
      $error("simon_round_ctrl: MAX_LEN must be in 1..15");
    end
    if (ON_TICKS < 1 || OFF_TICKS < 1 || TIMEOUT < 2) begin : g_bad_ticks
      $error("simon_round_ctrl: ON_TICKS/OFF_TICKS >= 1 and TIMEOUT >= 2 required");
    end
  endgenerate

  typedef enum logic [2:0] {
    IDLE     = 3'd0,
    LOAD     = 3'd1,
    SHOW_ON  = 3'd2,
    SHOW_OFF = 3'd3,
    WAIT_IN  = 3'd4,
    LEVEL_UP = 3'd5,
    WIN      = 3'd6,
    LOSE     = 3'd7
  } state_t;

  state_t               state_q, state_d;
  logic [3:0]           level_q, level_d;
  logic [3:0]           idx_q, idx_d;
  logic [TW-1:0]        timer_q, timer_d;
  logic [2*MAX_LEN-1:0] pat_q, pat_d;

  logic [1:0] curColor;
  logic       idxIsLast;

  // Shifting the pattern and truncating picks colour idx without an
  // out-of-range part-select when idx points past the stored colours.
  assign curColor  = 2'(pat_q >> {idx_q, 1'b0});
  assign idxIsLast = (idx_q == level_q - 4'd1);

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q <= IDLE;
      level_q <= '0;
      idx_q   <= '0;
      timer_q <= '0;
      pat_q   <= '0;
    end else begin
      state_q <= state_d;
      level_q <= level_d;
      idx_q   <= idx_d;
      timer_q <= timer_d;
      pat_q   <= pat_d;
    end
  end

  // Next-state logic. The timer restarts on every phase change so each
  // phase lasts exactly its tick count. A press in WAIT_IN is examined
  // before the timeout, so a press on the final idle cycle still counts.
  always_comb begin
    state_d = state_q;
    level_d = level_q;
    idx_d   = idx_q;
    timer_d = timer_q;
    pat_d   = pat_q;
    case (state_q)
      IDLE, WIN, LOSE: begin
        if (start) state_d = LOAD;
      end
      LOAD: begin
        pat_d   = pattern_in;
        level_d = 4'd1;
        idx_d   = '0;
        timer_d = '0;
        state_d = SHOW_ON;
      end
      SHOW_ON: begin
        if (timer_q == ON_LAST) begin
          timer_d = '0;
          state_d = SHOW_OFF;
        end else begin
          timer_d = timer_q + 1'b1;
        end
      end
      SHOW_OFF: begin
        if (timer_q == OFF_LAST) begin
          timer_d = '0;
          if (idxIsLast) begin
            idx_d   = '0;
            state_d = WAIT_IN;
          end else begin
            idx_d   = idx_q + 4'd1;
            state_d = SHOW_ON;
          end
        end else begin
          timer_d = timer_q + 1'b1;
        end
      end
      WAIT_IN: begin
        if (btn_valid) begin
          timer_d = '0;
          if (btn_color != curColor) begin
            state_d = LOSE;
          end else if (!idxIsLast) begin
            idx_d = idx_q + 4'd1;
          end else if (level_q == LAST_LEVEL) begin
            state_d = WIN;
          end else begin
            state_d = LEVEL_UP;
          end
        end else if (timer_q == TO_LAST) begin
          timer_d = '0;
          state_d = LOSE;
        end else begin
          timer_d = timer_q + 1'b1;
        end
      end
      LEVEL_UP: begin
        level_d = level_q + 4'd1;
        idx_d   = '0;
        timer_d = '0;
        state_d = SHOW_ON;
      end
      default: state_d = IDLE;
    endcase
  end

  // All outputs are decoded from registered state only.
  assign led       = (state_q == SHOW_ON) ? (4'b0001 << curColor) : 4'b0000;
  assign level     = level_q;
  assign busy      = (state_q != IDLE) && (state_q != WIN) && (state_q != LOSE);
  assign round_ok  = (state_q == LEVEL_UP);
  assign win       = (state_q == WIN);
  assign lose      = (state_q == LOSE);
  assign state_dbg = {1'b0, state_q};

endmodule
